din_conditioner: RTL and testbench
==================================

# din_conditioner

Input-conditioning stage that sits directly upstream of the flip-flop data input in the lab designs. It takes a raw, asynchronous, possibly bouncing signal (push-button or switch) and produces a clean, synchronous level for the flip-flop `d` pin. It also produces single-cycle rise/fall strobes and a wrapping transition counter. The flip-flop then samples a signal that changes at most once per debounce window and never violates setup/hold.

## Interface

- `DEBOUNCE`, default 4: consecutive stable cycles required before the output level changes; legal range 1..255.
- `CNT_W`, default 8: width of the transition counter.

- `clk`  input  1  rising-edge clock, single clock domain.
- `clear`  input  1  reset, asynchronous, active-high; clears all state immediately.
- `din_async`  input  1  raw asynchronous input.
- `d_clean`  output  1  debounced, synchronous level; feeds the flip-flop `d`.
- `rise`  output  1  one-cycle strobe when `d_clean` goes 0→1.
- `fall`  output  1  one-cycle strobe when `d_clean` goes 1→0.
- `toggles`  output  CNT_W  count of accepted transitions, modulo 2^CNT_W.

## Operation

- Synchronizer: two flops, `s1 <= din_async`, `s2 <= s1`. Only `s2` is used downstream.
- FSM states:
  - LOW: `d_clean=0`. Go to RISING when `s2=1`.
  - RISING: `d_clean=0`. Go back to LOW when `s2=0`. Go to HIGH when qualified.
  - HIGH: `d_clean=1`. Go to FALLING when `s2=0`.
  - FALLING: `d_clean=1`. Go back to HIGH when `s2=1`. Go to LOW when qualified.
- Stability counter, width clog2(DEBOUNCE+1):
  - Increments on every edge where `s2 != d_clean`.
  - Cleared on any edge where `s2 == d_clean`.
  - "Qualified" means `s2 != d_clean` while counter == DEBOUNCE-1. On that edge `d_clean` flips and the counter clears.
- Glitch rejection: an `s2` excursion shorter than DEBOUNCE cycles returns the FSM to LOW or HIGH with no output change, no strobe and no count.
- Strobes: `rise`/`fall` are registered and assert on the same edge that flips `d_clean`, for exactly one cycle. They are never both high. They are never high for two consecutive cycles.
- `toggles` increments by 1 on every `rise` or `fall`. Wrap is 2^CNT_W-1 → 0, with no saturation and no flag.
- `DEBOUNCE=1`: `d_clean` follows `s2` with one cycle of delay; the RISING and FALLING states last 0 cycles and are not visible.

## Timing

- Reset values (while `clear=1`): `s1=s2=0`, state LOW, counter 0, `d_clean=0`, `rise=fall=0`, `toggles=0`.
- Reset assertion takes effect without a clock edge.
- First state change is on the first rising `clk` edge after `clear` deasserts.
- Latency: `din_async` stable before edge k → `d_clean` and strobe change after edge k+1+DEBOUNCE, i.e. DEBOUNCE+2 edges. Default 4 gives 6 edges, 60 ns at a 10 ns period.
- Reset mid-qualification: counter and state are discarded. If `din_async` is still high after release, it is treated as a fresh rising edge and takes the full DEBOUNCE+2 latency.
- Input held high through reset: one `rise` and `toggles=1` after release plus latency.
- Input returning to the old level on exactly the qualifying edge (the edge that would flip): whatever `s2` shows at that edge decides the outcome. If `s2 != d_clean` at that edge, `d_clean` flips.
- Minimum spacing between `d_clean` transitions is DEBOUNCE cycles.

## Test plan

- Reset: assert `clear` mid-cycle with `din_async=1` → all outputs 0 immediately, with no clock edge needed. Release `clear` → `d_clean=1` and `rise` pulse 6 edges later, then `toggles=1`.
- Clean step: `din_async` 0→1, held 100 ns (DEBOUNCE=4, 10 ns clock) → `d_clean` rises 6 edges after the sampling edge with one `rise` pulse. Then 1→0 → `fall` pulse 6 edges later; `toggles=2`.
- Bounce: `din_async` pulses high 1, 2, then 3 cycles, separated by 1 low cycle, then stays low → `d_clean` stays 0, no strobes, `toggles=0`.
- Bounce then settle: 3 short glitches followed by a steady high → exactly one `rise`, occurring 6 edges after the last 0→1 sample; `toggles=1`.
- Wrap: CNT_W=2, DEBOUNCE=1, 5 clean transitions → `toggles` sequence 1, 2, 3, 0, 1.
- Boundary: DEBOUNCE=4, high pulse exactly 4 cycles long at `s2` → accepted, one `rise`. Same test with a 3-cycle pulse → rejected.

Source files
------------

// File: rtl/din_conditioner.sv
// Input conditioner: two-flop synchronizer, debounce FSM, rise/fall strobes
// and a wrapping transition counter feeding a flip-flop d pin.
module din_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             din_async,
  output logic             d_clean,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] toggles
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] QUAL_CNT = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             s1_r, s2_r;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             level_s, qual_s;
  logic             d_clean_nxt_s, rise_nxt_s, fall_nxt_s;
  logic             d_clean_r, rise_r, fall_r;
  logic [CNT_W-1:0] toggles_r;

  // Synchronizer, FSM state and stability counter registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      state_r <= ST_LOW;
      cnt_r   <= '0;
    end else begin
      s1_r    <= din_async;
      s2_r    <= s1_r;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Current accepted level and qualification of a pending change
  always_comb begin
    level_s = (state_r == ST_HIGH) || (state_r == ST_FALLING);
    qual_s  = (s2_r != level_s) && (cnt_r == QUAL_CNT);
  end

  // Next-state and stability counter logic; qualification wins over staying put
  always_comb begin
    state_nxt_s = state_r;
    if ((s2_r == level_s) || qual_s) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    case (state_r)
      ST_LOW: begin
        if (qual_s)      state_nxt_s = ST_HIGH;
        else if (s2_r)   state_nxt_s = ST_RISING;
        else             state_nxt_s = ST_LOW;
      end
      ST_RISING: begin
        if (!s2_r)       state_nxt_s = ST_LOW;
        else if (qual_s) state_nxt_s = ST_HIGH;
        else             state_nxt_s = ST_RISING;
      end
      ST_HIGH: begin
        if (qual_s)      state_nxt_s = ST_LOW;
        else if (!s2_r)  state_nxt_s = ST_FALLING;
        else             state_nxt_s = ST_HIGH;
      end
      ST_FALLING: begin
        if (s2_r)        state_nxt_s = ST_HIGH;
        else if (qual_s) state_nxt_s = ST_LOW;
        else             state_nxt_s = ST_FALLING;
      end
      default: begin
        state_nxt_s = ST_LOW;
      end
    endcase
  end

  // Output decode from the next state so outputs are registered alongside it
  always_comb begin
    d_clean_nxt_s = (state_nxt_s == ST_HIGH) || (state_nxt_s == ST_FALLING);
    rise_nxt_s    = qual_s && !level_s;
    fall_nxt_s    = qual_s && level_s;
  end

  // Registered outputs and wrapping transition counter
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      d_clean_r <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
      toggles_r <= '0;
    end else begin
      d_clean_r <= d_clean_nxt_s;
      rise_r    <= rise_nxt_s;
      fall_r    <= fall_nxt_s;
      if (qual_s) begin
        toggles_r <= toggles_r + CNT_W'(1);
      end else begin
        toggles_r <= toggles_r;
      end
    end
  end

  assign d_clean = d_clean_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign toggles = toggles_r;

endmodule

// File: tb/tb_din_conditioner.sv
// Directed bench for din_conditioner: default instance (DEBOUNCE=4) for
// latency/glitch/reset cases, second instance (DEBOUNCE=1, CNT_W=2) for wrap.
module tb_din_conditioner;

  logic       clk = 1'b0;
  logic       clear_a, din_a, d_clean_a, rise_a, fall_a;
  logic [7:0] toggles_a;
  logic       clear_b, din_b, d_clean_b, rise_b, fall_b;
  logic [1:0] toggles_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_seen = 0;
  int fall_seen = 0;
  int last_rise_cyc = 0;
  int last_fall_cyc = 0;
  int c0, r0, f0;
  int exp_tog [5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  din_conditioner u_dut_a (
    .clk(clk), .clear(clear_a), .din_async(din_a),
    .d_clean(d_clean_a), .rise(rise_a), .fall(fall_a), .toggles(toggles_a)
  );

  din_conditioner #(.DEBOUNCE(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .clear(clear_b), .din_async(din_b),
    .d_clean(d_clean_b), .rise(rise_b), .fall(fall_b), .toggles(toggles_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 ns after each edge and logging strobes of instance A
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rise_a) begin
        rise_seen++;
        last_rise_cyc = cyc;
      end
      if (fall_a) begin
        fall_seen++;
        last_fall_cyc = cyc;
      end
    end
  endtask

  task automatic pulse_a(input int hi);
    din_a = 1'b1;
    tick(hi);
    din_a = 1'b0;
    tick(1);
  endtask

  task automatic reset_a();
    clear_a = 1'b1;
    tick(1);
    clear_a = 1'b0;
  endtask

  initial begin
    clear_a = 1'b1; clear_b = 1'b1; din_a = 1'b0; din_b = 1'b0;
    tick(2);
    check_eq("rst_d_clean", d_clean_a, 0);
    check_eq("rst_rise", rise_a, 0);
    check_eq("rst_fall", fall_a, 0);
    check_eq("rst_toggles", toggles_a, 0);
    clear_a = 1'b0; clear_b = 1'b0;
    tick(2);

    // Clean step up then down
    c0 = cyc; r0 = rise_seen; din_a = 1'b1;
    tick(5);
    check_eq("step_pre", d_clean_a, 0);
    tick(1);
    check_eq("step_d_clean", d_clean_a, 1);
    check_eq("step_rise", rise_a, 1);
    check_eq("step_rise_lat", last_rise_cyc - c0, 6);
    tick(4);
    check_eq("step_rise_cnt", rise_seen - r0, 1);
    check_eq("step_tog1", toggles_a, 1);
    c0 = cyc; f0 = fall_seen; din_a = 1'b0;
    tick(8);
    check_eq("step_fall_cnt", fall_seen - f0, 1);
    check_eq("step_fall_lat", last_fall_cyc - c0, 6);
    check_eq("step_low", d_clean_a, 0);
    check_eq("step_tog2", toggles_a, 2);

    // Bounce only
    reset_a();
    r0 = rise_seen; f0 = fall_seen;
    pulse_a(1); pulse_a(2); pulse_a(3);
    tick(10);
    check_eq("bounce_rise", rise_seen - r0, 0);
    check_eq("bounce_fall", fall_seen - f0, 0);
    check_eq("bounce_d_clean", d_clean_a, 0);
    check_eq("bounce_tog", toggles_a, 0);

    // Bounce then settle high
    reset_a();
    pulse_a(1); pulse_a(2); pulse_a(3);
    r0 = rise_seen; c0 = cyc; din_a = 1'b1;
    tick(10);
    check_eq("settle_rise", rise_seen - r0, 1);
    check_eq("settle_lat", last_rise_cyc - c0, 6);
    check_eq("settle_tog", toggles_a, 1);

    // Boundary pulse widths
    reset_a();
    r0 = rise_seen;
    pulse_a(4);
    tick(10);
    check_eq("bnd4_rise", rise_seen - r0, 1);
    reset_a();
    r0 = rise_seen;
    pulse_a(3);
    tick(10);
    check_eq("bnd3_rise", rise_seen - r0, 0);
    check_eq("bnd3_tog", toggles_a, 0);

    // Asynchronous clear mid-cycle with input held high through reset
    reset_a();
    din_a = 1'b1;
    tick(8);
    check_eq("pre_clr_d_clean", d_clean_a, 1);
    #2 clear_a = 1'b1;
    #1;
    check_eq("async_clr_d_clean", d_clean_a, 0);
    check_eq("async_clr_tog", toggles_a, 0);
    tick(2);
    clear_a = 1'b0;
    c0 = cyc; r0 = rise_seen;
    tick(8);
    check_eq("rel_rise", rise_seen - r0, 1);
    check_eq("rel_lat", last_rise_cyc - c0, 6);
    check_eq("rel_tog", toggles_a, 1);

    // Counter wrap with DEBOUNCE=1, CNT_W=2
    for (int i = 0; i < 5; i++) begin
      din_b = ~din_b;
      tick(2);
      check_eq("wrap_pre", d_clean_b, !din_b);
      tick(1);
      check_eq("wrap_d_clean", d_clean_b, din_b);
      tick(1);
      check_eq("wrap_tog", toggles_b, exp_tog[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
